router_fifo: RTL and testbench

Per-destination output buffer of the 1x3 router; three instances sit directly downstream of the synchronizer, one per output port. Each stores packet bytes written under the synchronizer's one-hot `write_enb` bit and returns them to the destination client on `read_enb`. It reports `full` and `empty` back to the synchronizer, which uses them for `fifo_full`, `vld_out_x` and its 30-cycle soft-reset timeout. A header-length counter tracks packet boundaries on the read side.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_fifo_ram.sv | 28 ++
 rtl/router_fifo.sv | 99 +++++++++
 tb/tb_router_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and helpers for the 1x3 router datapath.
// Combinational only; no state.
// No flow control; consumed by the router blocks.
package router_pkg;

   localparam int FIFO_DEPTH = 16;
   localparam int BYTE_WIDTH = 8;
   localparam int HDR_BIT    = 8;

   // Header byte layout: payload length lives in bits [7:2]
   localparam int LEN_MSB    = 7;
   localparam int LEN_LSB    = 2;
   localparam int LEN_W      = LEN_MSB - LEN_LSB + 1;

   localparam int PKT_CNT_W  = 7;

   // Bytes still to come after a header: payload length plus the parity byte
   function automatic logic [PKT_CNT_W-1:0] hdr_pkt_count(input logic [LEN_W-1:0] len);
      return {1'b0, len} + PKT_CNT_W'(1);
   endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// Storage array for one router output FIFO: sync write, async read.
// Write lands on the rising edge; read data follows rd_addr combinationally.
// No flow control; the parent decides when a write is legal.
module router_fifo_ram #(
   parameter int DEPTH = 16,
   parameter int DW    = 9,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_dat,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_dat
);

   logic [DW-1:0] mem [DEPTH];

   // Write port; contents are never reset, pointers define what is valid
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router with header-length tracking.
// Read data registered: 1-cycle latency from an accepted read_enb.
// Writes while full are dropped; reads while empty are ignored.
module router_fifo
   import router_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int WIDTH = BYTE_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;
   logic [WIDTH-1:0]     data_out_q, data_out_d;

   logic                 wr_acc;
   logic                 rd_acc;
   logic                 flush;
   logic [WIDTH:0]       rd_entry;

   // Flags come only from registered pointers; the wrap bit separates full from empty
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign flush  = reset || soft_reset;
   assign wr_acc = write_enb && !full;
   assign rd_acc = read_enb && !empty;

   router_fifo_ram #(
      .DEPTH (DEPTH),
      .DW    (WIDTH + 1),
      .AW    (AW)
   ) u_ram (
      .clock   (clock),
      .wr_en   (wr_acc && !flush),
      .wr_addr (wr_ptr_q[AW-1:0]),
      .wr_dat  ({lfd_state, data_in}),
      .rd_addr (rd_ptr_q[AW-1:0]),
      .rd_dat  (rd_entry)
   );

   // Next-state for pointers, packet counter and output byte
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      pkt_count_d = pkt_count_q;
      data_out_d  = data_out_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         data_out_d = rd_entry[WIDTH-1:0];
         if (rd_entry[WIDTH]) begin
            pkt_count_d = hdr_pkt_count(rd_entry[LEN_MSB:LEN_LSB]);
         end else if (pkt_count_q != '0) begin
            pkt_count_d = pkt_count_q - PKT_CNT_W'(1);
         end
      end else if (pkt_count_q == '0) begin
         // Between packets the output bus idles at zero
         data_out_d = '0;
      end
   end

   // State update; hard and soft reset clear the same set of registers
   always_ff @(posedge clock) begin
      if (flush) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         pkt_count_q <= '0;
         data_out_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         pkt_count_q <= pkt_count_d;
         data_out_q  <= data_out_d;
      end
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
// Inputs change 1 time unit after each rising edge; outputs sampled there too.
// A queue model tracks contents during the wrap-around traffic run.
module tb_router_fifo;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       soft_reset = 1'b0;
   logic       write_enb = 1'b0;
   logic       read_enb = 1'b0;
   logic       lfd_state = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       full;
   logic       empty;

   int n_cmp = 0;
   int n_err = 0;

   router_fifo dut (
      .clock      (clock),
      .reset      (reset),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .read_enb   (read_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .data_out   (data_out),
      .full       (full),
      .empty      (empty)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic cyc(input logic we, input logic re, input logic lfd, input logic [7:0] d);
      write_enb = we;
      read_enb  = re;
      lfd_state = lfd;
      data_in   = d;
      step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] q[$];
   logic [7:0] exp_dout;
   logic       we;
   logic       re;
   logic       exp_rd;
   logic       exp_wr;

   initial begin
      // Reset state
      reset = 1'b1;
      cyc(0, 0, 0, 8'h00);
      reset = 1'b0;
      chk("rst_dout", 32'(data_out), 32'h00);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_empty", 32'(empty), 32'h1);

      // Single packet: header 0x0C (length 3) plus 3 payload and parity
      cyc(1, 0, 1, 8'h0C);
      chk("p1_empty_after_wr", 32'(empty), 32'h0);
      cyc(1, 0, 0, 8'hA1);
      cyc(1, 0, 0, 8'hA2);
      cyc(1, 0, 0, 8'hA3);
      cyc(1, 0, 0, 8'h5E);
      cyc(0, 1, 0, 8'h00); chk("p1_rd0", 32'(data_out), 32'h0C);
      cyc(0, 1, 0, 8'h00); chk("p1_rd1", 32'(data_out), 32'hA1);
      cyc(0, 1, 0, 8'h00); chk("p1_rd2", 32'(data_out), 32'hA2);
      cyc(0, 1, 0, 8'h00); chk("p1_rd3", 32'(data_out), 32'hA3);
      cyc(0, 1, 0, 8'h00); chk("p1_rd4", 32'(data_out), 32'h5E);
      chk("p1_empty_end", 32'(empty), 32'h1);
      cyc(0, 0, 0, 8'h00);
      chk("p1_idle_dout", 32'(data_out), 32'h00);
      chk("p1_idle_empty", 32'(empty), 32'h1);

      // Fill to capacity, overflow write dropped, drain in order
      for (int i = 0; i < 16; i++) begin
         cyc(1, 0, 0, 8'(i));
         if (i == 14) chk("fill_full_at15", 32'(full), 32'h0);
      end
      chk("fill_full_at16", 32'(full), 32'h1);
      chk("fill_not_empty", 32'(empty), 32'h0);
      cyc(1, 0, 0, 8'hFF);
      chk("ovf_full", 32'(full), 32'h1);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 1, 0, 8'h00);
         chk("fill_rd", 32'(data_out), 32'(i));
      end
      chk("fill_drained_empty", 32'(empty), 32'h1);
      chk("fill_drained_full", 32'(full), 32'h0);

      // Full FIFO with simultaneous read and write: write dropped
      for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(8'h10 + i));
      chk("rw_full_pre", 32'(full), 32'h1);
      cyc(1, 1, 0, 8'h55);
      chk("rw_full_rd", 32'(data_out), 32'h10);
      chk("rw_full_post", 32'(full), 32'h0);
      for (int i = 1; i < 16; i++) begin
         cyc(0, 1, 0, 8'h00);
         chk("rw_full_drain", 32'(data_out), 32'(8'h10 + i));
      end
      chk("rw_full_dropped", 32'(empty), 32'h1);

      // Empty FIFO with simultaneous read and write: read ignored
      cyc(0, 0, 0, 8'h00);
      chk("rw_empty_idle", 32'(data_out), 32'h00);
      cyc(1, 1, 0, 8'h33);
      chk("rw_empty_dout", 32'(data_out), 32'h00);
      chk("rw_empty_flag", 32'(empty), 32'h0);
      cyc(0, 1, 0, 8'h00);
      chk("rw_empty_rd", 32'(data_out), 32'h33);
      chk("rw_empty_end", 32'(empty), 32'h1);

      // Soft reset mid-packet: header 0x08 (length 2) + 2 payload + parity
      cyc(1, 0, 1, 8'h08);
      cyc(1, 0, 0, 8'hB1);
      cyc(1, 0, 0, 8'hB2);
      cyc(1, 0, 0, 8'hB3);
      cyc(0, 1, 0, 8'h00); chk("sr_rd0", 32'(data_out), 32'h08);
      cyc(0, 1, 0, 8'h00); chk("sr_rd1", 32'(data_out), 32'hB1);
      cyc(0, 0, 0, 8'h00); chk("sr_hold_midpkt", 32'(data_out), 32'hB1);
      soft_reset = 1'b1;
      cyc(0, 0, 0, 8'h00);
      soft_reset = 1'b0;
      chk("sr_empty", 32'(empty), 32'h1);
      chk("sr_full", 32'(full), 32'h0);
      chk("sr_dout", 32'(data_out), 32'h00);
      soft_reset = 1'b1;
      cyc(1, 0, 0, 8'h77);
      soft_reset = 1'b0;
      chk("sr_wr_discard", 32'(empty), 32'h1);
      cyc(1, 0, 1, 8'h04);
      cyc(1, 0, 0, 8'hC1);
      cyc(1, 0, 0, 8'hC2);
      cyc(0, 1, 0, 8'h00); chk("sr_new_hdr", 32'(data_out), 32'h04);
      cyc(0, 1, 0, 8'h00); chk("sr_new_b1", 32'(data_out), 32'hC1);
      cyc(0, 1, 0, 8'h00); chk("sr_new_par", 32'(data_out), 32'hC2);
      cyc(0, 0, 0, 8'h00); chk("sr_new_idle", 32'(data_out), 32'h00);
      chk("sr_new_empty", 32'(empty), 32'h1);

      // Interleaved traffic through several pointer wraps, checked against a queue
      q.delete();
      for (int i = 0; i < 400; i++) begin
         case ((i / 40) % 3)
            0:       begin we = 1'b1;          re = (i % 3 == 0); end
            1:       begin we = (i % 2 == 0);  re = (i % 2 == 1); end
            default: begin we = (i % 3 == 0);  re = 1'b1;         end
         endcase
         exp_rd   = re && (q.size() != 0);
         exp_wr   = we && (q.size() != 16);
         exp_dout = 8'h00;
         if (exp_rd) exp_dout = q.pop_front();
         if (exp_wr) q.push_back(8'(i * 7 + 3));
         cyc(we, re, 0, 8'(i * 7 + 3));
         chk("wrap_dout", 32'(data_out), 32'(exp_dout));
         chk("wrap_empty", 32'(empty), 32'(q.size() == 0));
         chk("wrap_full", 32'(full), 32'(q.size() == 16));
         chk("wrap_flags_excl", 32'(full && empty), 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
